// File: rtl/zigzag_encryption.sv
// Rail-fence (zigzag) encryptor: buffers plaintext until the start token, then
// streams the ciphertext rail by rail, one character per cycle.
module zigzag_encryption #(
    parameter int unsigned         D_WIDTH                = 8,
    parameter int unsigned         KEY_WIDTH              = 16,
    parameter int unsigned         MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]  START_ENCRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int unsigned AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam int unsigned PW = KEY_WIDTH + 1;
    localparam int unsigned SW = KEY_WIDTH + 2;

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t               state;
    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
    logic [KEY_WIDTH-1:0] n;
    logic [KEY_WIDTH-1:0] key_q;
    logic [KEY_WIDTH-1:0] rail;
    logic [KEY_WIDTH-1:0] idx;
    logic [KEY_WIDTH-1:0] cnt;
    logic                 phase;

    logic [PW-1:0]        period;
    logic [PW-1:0]        two_r;
    logic [PW-1:0]        s1;
    logic [PW-1:0]        s2;
    logic [PW-1:0]        step;
    logic                 use_s1;
    logic [SW-1:0]        idx_step;
    logic [KEY_WIDTH-1:0] nxt_rail;
    logic [KEY_WIDTH-1:0] nxt_idx;
    logic                 nxt_phase;

    // Next read pointer; a rail whose next index runs past n hands over to the next rail.
    always_comb begin
        period    = (PW'(key_q) - PW'(1)) << 1;
        two_r     = PW'(rail) << 1;
        s1        = period - two_r;
        s2        = two_r;
        use_s1    = (!phase && (s1 != '0)) || (s2 == '0);
        step      = (key_q < KEY_WIDTH'(2)) ? PW'(1) : (use_s1 ? s1 : s2);
        idx_step  = SW'(idx) + SW'(step);
        nxt_rail  = rail;
        nxt_idx   = KEY_WIDTH'(idx_step);
        nxt_phase = ~phase;
        if (idx_step >= SW'(n)) begin
            nxt_rail  = rail + KEY_WIDTH'(1);
            nxt_idx   = rail + KEY_WIDTH'(1);
            nxt_phase = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= COLLECT;
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            n       <= '0;
            key_q   <= '0;
            rail    <= '0;
            idx     <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
            for (int unsigned i = 0; i < MAX_NOF_CHARS; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    if (valid_i) begin
                        if (data_i == START_ENCRYPTION_TOKEN) begin
                            key_q <= key;
                            busy  <= 1'b1;
                            state <= EMIT;
                            rail  <= '0;
                            idx   <= '0;
                            cnt   <= '0;
                            phase <= 1'b0;
                        end else if (n < KEY_WIDTH'(MAX_NOF_CHARS)) begin
                            mem[AW'(n)] <= data_i;
                            n           <= n + KEY_WIDTH'(1);
                        end
                    end
                end
                EMIT: begin
                    // Termination is by emitted count, never by running out of rails.
                    if (cnt == n) begin
                        valid_o <= 1'b0;
                        data_o  <= '0;
                        busy    <= 1'b0;
                        n       <= '0;
                        state   <= COLLECT;
                    end else begin
                        valid_o <= 1'b1;
                        data_o  <= mem[AW'(idx)];
                        cnt     <= cnt + KEY_WIDTH'(1);
                        rail    <= nxt_rail;
                        idx     <= nxt_idx;
                        phase   <= nxt_phase;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
